fnd_ctrl_axil: RTL and testbench

- Parametrised AXI4-Lite 7-segment (FND) display controller; successor to the fixed 4-register FND IP.
- Scans NUM_DIGITS multiplexed hex digits with a software-programmable refresh prescaler, per-digit decimal point, enable and a read-only status register.
- Sits on the PS/MicroBlaze AXI interconnect as a slave and drives board common/segment pins directly.

---
 rtl/fnd_pkg.sv | 51 +++++
 rtl/fnd_scan.sv | 119 +++++++++++
 rtl/fnd_ctrl_axil.sv | 199 +++++++++++++++++++
 tb/tb_fnd_ctrl_axil.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared definitions for the AXI4-Lite 7-segment controller: register map,
// response codes, write-channel states and the hex-to-segment decoder.
package fnd_pkg;

   // Register word indices (byte offset >> 2)
   localparam logic [2:0] RegCtrl     = 3'd0;
   localparam logic [2:0] RegData     = 3'd1;
   localparam logic [2:0] RegDp       = 3'd2;
   localparam logic [2:0] RegPrescale = 3'd3;
   localparam logic [2:0] RegStatus   = 3'd4;

   // Field bit positions
   localparam int unsigned CtrlEnBit      = 0;
   localparam int unsigned CtrlBlinkBit   = 1;
   localparam int unsigned StatusPhaseBit = 8;

   // AXI response encodings
   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;

   typedef enum logic [1:0] {
      WrIdle,
      WrAck,
      WrResp
   } wr_state_e;

   // Active-high segment pattern, bit order {g,f,e,d,c,b,a}
   function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
      logic [6:0] seg;
      case (hex)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/fnd_scan.sv
// Digit scanner: refresh prescaler, digit index, output registers and, when
// built with FND_BLINK_EN, the frame-based blink phase generator.
module fnd_scan
   import fnd_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter logic [15:0] PRESCALE_RST   = 16'd1000,
   parameter bit          COM_ACTIVE_LOW = 1'b1,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      en_i,
   input  logic                      blink_en_i,
   input  logic                      blink_clr_i,
   input  logic [15:0]               prescale_i,
   input  logic [4*NUM_DIGITS-1:0]   data_i,
   input  logic [NUM_DIGITS-1:0]     dp_i,
   output logic [NUM_DIGITS-1:0]     com_o,
   output logic [7:0]                seg_o,
   output logic [2:0]                idx_o,
   output logic                      phase_o
);

   localparam logic [2:0]            LastIdx = 3'(NUM_DIGITS - 1);
   localparam logic [15:0]           RstLoad = (PRESCALE_RST == 16'd0) ? 16'd1 : PRESCALE_RST;
   localparam logic [NUM_DIGITS-1:0] ComOff  = {NUM_DIGITS{COM_ACTIVE_LOW}};
   localparam logic [7:0]            SegOff  = {8{SEG_ACTIVE_LOW}};

   logic [15:0]           cnt_q, reload;
   logic [2:0]            idx_q;
   logic                  tick, wrap, blank;
   logic [NUM_DIGITS-1:0] com_q, com_d, com_hi;
   logic [7:0]            seg_q, seg_d;
   logic [3:0]            nib;
   logic                  dp_bit;

   // A programmed prescale of 0 behaves as 1
   assign reload = (prescale_i == 16'd0) ? 16'd1 : prescale_i;
   assign tick   = en_i && (cnt_q == 16'd0);
   assign wrap   = tick && (idx_q == LastIdx);

   // Prescaler and digit index; both parked (loaded / digit 0) while disabled
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= RstLoad;
         idx_q <= 3'd0;
      end else if (!en_i) begin
         cnt_q <= reload;
         idx_q <= 3'd0;
      end else if (tick) begin
         cnt_q <= reload;
         idx_q <= wrap ? 3'd0 : idx_q + 3'd1;
      end else begin
         cnt_q <= cnt_q - 16'd1;
      end
   end

`ifdef FND_BLINK_EN
   logic [7:0] frame_q;
   logic       phase_q;

   // Count 256 full frames per phase; clearing CTRL[1] restarts in the shown phase
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         frame_q <= 8'd0;
         phase_q <= 1'b0;
      end else if (blink_clr_i) begin
         frame_q <= 8'd0;
         phase_q <= 1'b1;
      end else if (wrap) begin
         frame_q <= frame_q + 8'd1;
         if (frame_q == 8'hFF) begin
            phase_q <= !phase_q;
         end
      end
   end

   assign blank   = blink_en_i && !phase_q;
   assign phase_o = phase_q;
`else
   logic unused_blink;
   assign unused_blink = blink_en_i ^ blink_clr_i;
   assign blank        = 1'b0;
   assign phase_o      = 1'b0;
`endif

   // Select the current digit's nibble/dp and build the pin pattern
   always_comb begin
      nib    = 4'h0;
      dp_bit = 1'b0;
      com_hi = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == 3'(i)) begin
            com_hi[i] = 1'b1;
            nib       = data_i[4*i +: 4];
            dp_bit    = dp_i[i];
         end
      end
      com_d = com_hi ^ ComOff;
      seg_d = blank ? SegOff : ({dp_bit, hex_to_seg(nib)} ^ SegOff);
   end

   // Registered pins; inactive whenever scanning is off
   always_ff @(posedge clk_i) begin
      if (!rst_ni || !en_i) begin
         com_q <= ComOff;
         seg_q <= SegOff;
      end else begin
         com_q <= com_d;
         seg_q <= seg_d;
      end
   end

   assign com_o = com_q;
   assign seg_o = seg_q;
   assign idx_o = idx_q;

endmodule

// File: rtl/fnd_ctrl_axil.sv
// AXI4-Lite slave front end for the multiplexed 7-segment display: write FSM,
// read channel, register file and the scanner instance.
// Optional blink support is compiled in with FND_BLINK_EN.
module fnd_ctrl_axil
   import fnd_pkg::*;
#(
   parameter int unsigned NUM_DIGITS         = 4,
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
   parameter logic [15:0] PRESCALE_RST       = 16'd1000,
   parameter bit          COM_ACTIVE_LOW     = 1'b1,
   parameter bit          SEG_ACTIVE_LOW     = 1'b1
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [NUM_DIGITS-1:0]           fnd_com,
   output logic [7:0]                      fnd_seg
);

   wr_state_e               wr_st_q;
   logic                    awready_q, bvalid_q, arready_q, rvalid_q;
   logic [31:0]             rdata_q;
   logic                    ctrl_en_q, ctrl_blink, blink_clr;
   logic [4*NUM_DIGITS-1:0] data_q;
   logic [NUM_DIGITS-1:0]   dp_q;
   logic [15:0]             prescale_q;
   logic [2:0]              scan_idx;
   logic                    scan_phase;
   logic [31:0]             reg_word [8];
   logic [31:0]             wr_old, wr_val, rd_word;
   logic [2:0]              wr_sel, rd_sel;
   logic                    wr_fire;
   logic                    unused_sig;

   assign wr_sel  = S_AXI_AWADDR[4:2];
   assign rd_sel  = S_AXI_ARADDR[4:2];
   assign wr_fire = (wr_st_q == WrAck);

   // Write FSM: one-cycle AW/W ready pulse, then hold B until BREADY
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         wr_st_q   <= WrIdle;
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
      end else begin
         case (wr_st_q)
            WrIdle: begin
               if (S_AXI_AWVALID && S_AXI_WVALID) begin
                  wr_st_q   <= WrAck;
                  awready_q <= 1'b1;
               end
            end
            WrAck: begin
               wr_st_q   <= WrResp;
               awready_q <= 1'b0;
               bvalid_q  <= 1'b1;
            end
            WrResp: begin
               if (S_AXI_BREADY) begin
                  wr_st_q  <= WrIdle;
                  bvalid_q <= 1'b0;
               end
            end
            default: wr_st_q <= WrIdle;
         endcase
      end
   end

   // Readback view of every word slot; unimplemented bits and slots are zero
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         reg_word[i] = '0;
      end
      reg_word[RegCtrl][CtrlEnBit]            = ctrl_en_q;
      reg_word[RegCtrl][CtrlBlinkBit]         = ctrl_blink;
      reg_word[RegData][4*NUM_DIGITS-1:0]     = data_q;
      reg_word[RegDp][NUM_DIGITS-1:0]         = dp_q;
      reg_word[RegPrescale][15:0]             = prescale_q;
      reg_word[RegStatus][2:0]                = scan_idx;
      reg_word[RegStatus][StatusPhaseBit]     = scan_phase;
   end

   assign wr_old  = reg_word[wr_sel];
   assign rd_word = reg_word[rd_sel];

   // Byte-strobe merge of new data over the current register contents
   always_comb begin
      for (int b = 0; b < 4; b++) begin
         wr_val[8*b +: 8] = S_AXI_WSTRB[b] ? S_AXI_WDATA[8*b +: 8] : wr_old[8*b +: 8];
      end
   end

   // Register file update on the write handshake cycle
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         ctrl_en_q  <= 1'b0;
         data_q     <= '0;
         dp_q       <= '0;
         prescale_q <= PRESCALE_RST;
      end else if (wr_fire) begin
         case (wr_sel)
            RegCtrl:     ctrl_en_q  <= wr_val[CtrlEnBit];
            RegData:     data_q     <= wr_val[4*NUM_DIGITS-1:0];
            RegDp:       dp_q       <= wr_val[NUM_DIGITS-1:0];
            RegPrescale: prescale_q <= wr_val[15:0];
            default: ;
         endcase
      end
   end

`ifdef FND_BLINK_EN
   logic blink_q;

   // CTRL[1] storage; writing it as 0 also re-arms the blink phase
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         blink_q <= 1'b0;
      end else if (wr_fire && (wr_sel == RegCtrl)) begin
         blink_q <= wr_val[CtrlBlinkBit];
      end
   end

   assign ctrl_blink = blink_q;
   assign blink_clr  = wr_fire && (wr_sel == RegCtrl) && !wr_val[CtrlBlinkBit];
`else
   assign ctrl_blink = 1'b0;
   assign blink_clr  = 1'b0;
`endif

   // Read channel: ARREADY tracks !RVALID (low during reset), data captured at handshake
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else if (arready_q && S_AXI_ARVALID) begin
         arready_q <= 1'b0;
         rvalid_q  <= 1'b1;
         rdata_q   <= rd_word;
      end else if (rvalid_q && S_AXI_RREADY) begin
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
      end else begin
         arready_q <= !rvalid_q;
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = awready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = RespOkay;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = RespOkay;

   assign unused_sig = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         wr_val};

   fnd_scan #(
      .NUM_DIGITS     (NUM_DIGITS),
      .PRESCALE_RST   (PRESCALE_RST),
      .COM_ACTIVE_LOW (COM_ACTIVE_LOW),
      .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
   ) u_scan (
      .clk_i       (ACLK),
      .rst_ni      (ARESETN),
      .en_i        (ctrl_en_q),
      .blink_en_i  (ctrl_blink),
      .blink_clr_i (blink_clr),
      .prescale_i  (prescale_q),
      .data_i      (data_q),
      .dp_i        (dp_q),
      .com_o       (fnd_com),
      .seg_o       (fnd_seg),
      .idx_o       (scan_idx),
      .phase_o     (scan_phase)
   );

endmodule

// File: tb/tb_fnd_ctrl_axil.sv
// Self-checking bench for fnd_ctrl_axil (4 digits, active-low pins).
module tb_fnd_ctrl_axil;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic [4:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        arvalid, arready, rvalid, rready;
   logic [N-1:0] fnd_com;
   logic [7:0]  fnd_seg;

   int total = 0;
   int bad   = 0;

   // Reference 7-segment shapes, {g..a} active high
   logic [6:0] seg7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   always #5 clk = ~clk;

   fnd_ctrl_axil dut (
      .ACLK          (clk),
      .ARESETN       (rstn),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .fnd_com       (fnd_com),
      .fnd_seg       (fnd_seg)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: handshake never completed", name);
   endtask

   task automatic aw_start(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
   endtask

   // Returns just after the handshake edge
   task automatic aw_wait();
      int n = 0;
      while (!(awready && wready) && n < 50) begin @(posedge clk); #1; n++; end
      if (!(awready && wready)) begin
         timeout("aw_wait"); awvalid = 1'b0; wvalid = 1'b0; return;
      end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic b_wait(output logic [1:0] resp);
      int n = 0;
      bready = 1'b1;
      while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
      if (!bvalid) begin timeout("b_wait"); resp = 2'b11; return; end
      resp = bresp;
      @(posedge clk); #1;
   endtask

   task automatic ar_wait();
      int n = 0;
      while (!arready && n < 50) begin @(posedge clk); #1; n++; end
      if (!arready) begin timeout("ar_wait"); arvalid = 1'b0; return; end
      @(posedge clk); #1;
      arvalid = 1'b0;
   endtask

   task automatic r_wait(output logic [31:0] d, output logic [1:0] resp);
      int n = 0;
      rready = 1'b1;
      while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
      if (!rvalid) begin timeout("r_wait"); d = 'x; resp = 2'b11; return; end
      d = rdata; resp = rresp;
      @(posedge clk); #1;
   endtask

   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      aw_start(a, d, s);
      aw_wait();
      b_wait(resp);
   endtask

   task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
      araddr = a; arvalid = 1'b1;
      ar_wait();
      r_wait(d, resp);
   endtask

   // Expected {com,seg} j cycles after the enabling write handshake
   function automatic logic [11:0] model(input int j, input logic [15:0] p,
                                         input logic [15:0] data, input logic [3:0] dp,
                                         input bit blink);
      int pe, dig, period;
      logic [3:0] nib, com;
      logic [7:0] seg;
      bit blank;
      if (j == 0) return 12'hFFF;
      pe     = (p == 16'd0) ? 1 : int'(p);
      period = 256 * N * (pe + 1);
      dig    = ((j - 1) / (pe + 1)) % N;
      nib    = 4'((data >> (4 * dig)) & 16'hF);
      blank  = blink && ((((j - 1) / period) % 2) == 1);
      com    = 4'hF & ~(4'b0001 << dig);
      seg    = blank ? 8'hFF : ~{dp[dig], seg7[nib]};
      return {com, seg};
   endfunction

   task automatic run_scan(input logic [15:0] p, input logic [15:0] data, input logic [3:0] dp,
                           input int ncyc, input bit blink);
      logic [1:0] r;
      axi_write(5'h00, 32'h0, 4'hF, r);
      axi_write(5'h04, {16'h0, data}, 4'hF, r);
      axi_write(5'h08, {28'h0, dp}, 4'hF, r);
      axi_write(5'h0C, {16'h0, p}, 4'hF, r);
      bready = 1'b1;
      aw_start(5'h00, blink ? 32'h3 : 32'h1, 4'hF);
      aw_wait();
      for (int j = 0; j < ncyc; j++) begin
         check($sformatf("scan p=%0d j=%0d", p, j), {20'h0, fnd_com, fnd_seg},
               {20'h0, model(j, p, data, dp, blink)});
         @(posedge clk); #1;
      end
   endtask

   initial begin
      vec_t        vecs [8];
      logic [31:0] d;
      logic [1:0]  r;
      logic [15:0] rp, rdat;
      logic [3:0]  rdp;

      vecs[0] = '{5'h00, 32'h0000_0001, 32'h1};
      vecs[1] = '{5'h04, 32'hFFFF_1234, 32'h1234};
      vecs[2] = '{5'h08, 32'h0000_000F, 32'hF};
      vecs[3] = '{5'h0C, 32'h0000_0002, 32'h2};
      vecs[4] = '{5'h18, 32'hDEAD_BEEF, 32'h0};
      vecs[5] = '{5'h14, 32'h1234_5678, 32'h0};
`ifdef FND_BLINK_EN
      vecs[6] = '{5'h00, 32'h0000_0003, 32'h3};
`else
      vecs[6] = '{5'h00, 32'h0000_0003, 32'h1};
`endif
      vecs[7] = '{5'h08, 32'hFFFF_FF35, 32'h5};

      awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
      araddr = '0; arvalid = 1'b0; rready = 1'b1; awprot = '0; arprot = '0;

      // Reset state
      rstn = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("reset ready/valid", {28'h0, awready, bvalid, arready, rvalid}, 32'h0);
      rstn = 1'b1;
      check("reset pins", {20'h0, fnd_com, fnd_seg}, 32'hFFF);
      axi_read(5'h00, d, r); check("reset CTRL", d, 32'h0);
      axi_read(5'h04, d, r); check("reset DATA", d, 32'h0);
      axi_read(5'h08, d, r); check("reset DP", d, 32'h0);
      axi_read(5'h0C, d, r); check("reset PRESCALE", d, 32'h3E8);
      axi_read(5'h10, d, r); check("reset STATUS", d, 32'h0);

      // Register readback table
      foreach (vecs[i]) begin
         axi_write(vecs[i].addr, vecs[i].wdata, 4'hF, r);
         check($sformatf("BRESP @%0h", vecs[i].addr), {30'h0, r}, 32'h0);
         axi_read(vecs[i].addr, d, r);
         check($sformatf("readback @%0h", vecs[i].addr), d, vecs[i].exp);
         check($sformatf("RRESP @%0h", vecs[i].addr), {30'h0, r}, 32'h0);
      end

      // Byte strobes: only byte 1 of DATA changes
      axi_write(5'h04, 32'hAABB_CCDD, 4'b0010, r);
      axi_read(5'h04, d, r); check("wstrb DATA", d, 32'hCC34);
      axi_read(5'h18, d, r); check("hole read", d, 32'h0);
      check("hole RRESP", {30'h0, r}, 32'h0);

      // Write backpressure: B held, second write stalled
      axi_write(5'h0C, 32'h77, 4'hF, r);
      bready = 1'b0;
      aw_start(5'h08, 32'h5, 4'hF);
      aw_wait();
      aw_start(5'h08, 32'hA, 4'hF);
      for (int i = 0; i < 10; i++) begin
         check("b hold", {30'h0, bvalid, awready}, 32'h2);
         @(posedge clk); #1;
      end
      b_wait(r);
      aw_wait();
      b_wait(r);
      axi_read(5'h08, d, r); check("second write", d, 32'hA);

      // Read backpressure: R held, ARREADY low
      rready = 1'b0;
      araddr = 5'h0C; arvalid = 1'b1;
      ar_wait();
      for (int i = 0; i < 10; i++) begin
         check("r hold", {30'h0, rvalid, arready}, 32'h2);
         check("r data hold", rdata, 32'h77);
         @(posedge clk); #1;
      end
      r_wait(d, r); check("r after hold", d, 32'h77);

      // Scan, known pattern then random ones
      run_scan(16'd2, 16'h1234, 4'h0, 30, 1'b0);
      for (int t = 0; t < 4; t++) begin
         rp   = 16'($urandom_range(0, 4));
         rdat = 16'($urandom);
         rdp  = 4'($urandom);
         run_scan(rp, rdat, rdp, 8 * (((rp == 0) ? 1 : int'(rp)) + 1) + 3, 1'b0);
      end

      // Disable parks everything
      axi_write(5'h00, 32'h0, 4'hF, r);
      repeat (2) @(posedge clk);
      #1;
      check("disabled pins", {20'h0, fnd_com, fnd_seg}, 32'hFFF);
      axi_read(5'h10, d, r); check("disabled STATUS idx", {29'h0, d[2:0]}, 32'h0);

      // Reset in the middle of a pending read while scanning
      axi_write(5'h0C, 32'h1, 4'hF, r);
      axi_write(5'h00, 32'h1, 4'hF, r);
      rready = 1'b0;
      araddr = 5'h0C; arvalid = 1'b1;
      ar_wait();
      check("pre-reset RVALID", {31'h0, rvalid}, 32'h1);
      rstn = 1'b0;
      @(posedge clk); #1;
      check("mid reset RVALID", {31'h0, rvalid}, 32'h0);
      check("mid reset pins", {20'h0, fnd_com, fnd_seg}, 32'hFFF);
      rstn = 1'b1;
      rready = 1'b1;
      axi_read(5'h0C, d, r); check("post reset PRESCALE", d, 32'h3E8);
      axi_read(5'h00, d, r); check("post reset CTRL", d, 32'h0);

`ifdef FND_BLINK_EN
      run_scan(16'd1, 16'h1234, 4'h2, 4200, 1'b1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
